// File: rtl/instr_fetch.sv
// Instruction fetch unit for the 6502 softcore: reads opcode/operand bytes from a
// synchronous byte memory, sizes each instruction and hands it to the decoder.
module instr_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0200
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [7:0]  instr_opcode,
  output logic [7:0]  instr_op1,
  output logic [7:0]  instr_op2,
  output logic [1:0]  instr_size,
  output logic [15:0] instr_pc,
  output logic [15:0] pc_next,
  output logic [2:0]  dbg_state
);

  // Handshake: an instruction transfers on a rising edge where instr_valid && instr_ready;
  // once valid is high the instruction fields do not change until that transfer or a redirect.

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_BYTE1  = 3'd3,
    S_BYTE2  = 3'd4,
    S_HOLD   = 3'd5
  } state_t;

  state_t      state;
  logic [15:0] fpc;
  logic [1:0]  dec_size;
  logic        redir;
  logic        rd_en;
  logic [15:0] rd_addr;

  function automatic logic [1:0] op_len(input logic [7:0] op);
    case (op)
      8'h4C: op_len = 2'd3;
      8'hA9, 8'hA5, 8'hA2, 8'hA6, 8'hA0, 8'hA4, 8'h85, 8'h86, 8'h84,
      8'h69, 8'hE9, 8'h29, 8'h49, 8'h45, 8'h09, 8'h05, 8'hE6, 8'hC6,
      8'hF0, 8'hD0, 8'hB0, 8'h90, 8'h30, 8'h10, 8'h50, 8'h70:
        op_len = 2'd2;
      default: op_len = 2'd1;
    endcase
  endfunction

  assign dec_size  = op_len(mem_rdata);
  // Redirect cannot interrupt the post-reset cycle.
  assign redir     = redirect && (state != S_RST);
  assign dbg_state = state;
  assign pc_next   = instr_pc + {14'd0, instr_size};

  always_comb begin
    rd_en   = 1'b0;
    rd_addr = fpc;
    case (state)
      S_FETCH: begin
        rd_en   = 1'b1;
        rd_addr = fpc;
      end
      S_DECODE: begin
        rd_en   = (dec_size != 2'd1);
        rd_addr = fpc + 16'd1;
      end
      S_BYTE1: begin
        rd_en   = (instr_size == 2'd3);
        rd_addr = fpc + 16'd2;
      end
      S_HOLD: begin
        rd_en   = instr_ready;
        rd_addr = fpc + {14'd0, instr_size};
      end
      default: begin
        rd_en   = 1'b0;
        rd_addr = fpc;
      end
    endcase
    if (redir) rd_en = 1'b0;
  end

  assign mem_rd   = rd_en;
  assign mem_addr = rd_en ? rd_addr : 16'h0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_RST;
      fpc          <= RESET_PC;
      instr_valid  <= 1'b0;
      instr_opcode <= 8'h00;
      instr_op1    <= 8'h00;
      instr_op2    <= 8'h00;
      instr_size   <= 2'd1;
      instr_pc     <= RESET_PC;
    end else if (redir) begin
      fpc         <= redirect_pc;
      state       <= S_FETCH;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_RST:   state <= S_FETCH;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          instr_opcode <= mem_rdata;
          instr_pc     <= fpc;
          instr_op1    <= 8'h00;
          instr_op2    <= 8'h00;
          instr_size   <= dec_size;
          if (dec_size == 2'd1) begin
            state       <= S_HOLD;
            instr_valid <= 1'b1;
          end else begin
            state <= S_BYTE1;
          end
        end
        S_BYTE1: begin
          instr_op1 <= mem_rdata;
          if (instr_size == 2'd3) begin
            state <= S_BYTE2;
          end else begin
            state       <= S_HOLD;
            instr_valid <= 1'b1;
          end
        end
        S_BYTE2: begin
          instr_op2   <= mem_rdata;
          state       <= S_HOLD;
          instr_valid <= 1'b1;
        end
        S_HOLD: begin
          // The next opcode read was issued this cycle, so go straight to DECODE.
          if (instr_ready) begin
            fpc         <= fpc + {14'd0, instr_size};
            instr_valid <= 1'b0;
            state       <= S_DECODE;
          end
        end
        default: state <= S_RST;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized run scored against
// a memory-walking instruction model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_rd, mem_rd_w;
  logic [15:0] mem_addr, mem_addr_w;
  logic [7:0]  mem_rdata, mem_rdata_w;
  logic        redirect = 1'b0, redirect_w = 1'b0;
  logic [15:0] redirect_pc = 16'h0, redirect_pc_w = 16'h0;
  logic        instr_valid, instr_valid_w;
  logic        instr_ready = 1'b0, instr_ready_w = 1'b0;
  logic [7:0]  instr_opcode, instr_op1, instr_op2;
  logic [7:0]  instr_opcode_w, instr_op1_w, instr_op2_w;
  logic [1:0]  instr_size, instr_size_w;
  logic [15:0] instr_pc, instr_pc_w, pc_next, pc_next_w;
  logic [2:0]  dbg_state, dbg_state_w;

  instr_fetch u_dut (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_opcode(instr_opcode), .instr_op1(instr_op1),
    .instr_op2(instr_op2), .instr_size(instr_size), .instr_pc(instr_pc),
    .pc_next(pc_next), .dbg_state(dbg_state)
  );

  instr_fetch #(.RESET_PC(16'hFFFE)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .mem_rd(mem_rd_w), .mem_addr(mem_addr_w), .mem_rdata(mem_rdata_w),
    .redirect(redirect_w), .redirect_pc(redirect_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(instr_ready_w), .instr_opcode(instr_opcode_w), .instr_op1(instr_op1_w),
    .instr_op2(instr_op2_w), .instr_size(instr_size_w), .instr_pc(instr_pc_w),
    .pc_next(pc_next_w), .dbg_state(dbg_state_w)
  );

  wire [41:0] dut_instr   = {instr_pc, instr_opcode, instr_op1, instr_op2, instr_size};
  wire [41:0] dut_instr_w = {instr_pc_w, instr_opcode_w, instr_op1_w, instr_op2_w, instr_size_w};

  // ---------------- clock / memory ----------------
  always #5 clk = ~clk;

  logic [7:0] mem [0:65535];

  always @(posedge clk) begin
    mem_rdata   <= mem_rd   ? mem[mem_addr]   : 8'($urandom);
    mem_rdata_w <= mem_rd_w ? mem[mem_addr_w] : 8'($urandom);
  end

  // ---------------- reference model ----------------
  logic [7:0] two_byte_ops [26] = '{8'hA9, 8'hA5, 8'hA2, 8'hA6, 8'hA0, 8'hA4, 8'h85, 8'h86,
                                    8'h84, 8'h69, 8'hE9, 8'h29, 8'h49, 8'h45, 8'h09, 8'h05,
                                    8'hE6, 8'hC6, 8'hF0, 8'hD0, 8'hB0, 8'h90, 8'h30, 8'h10,
                                    8'h50, 8'h70};

  function automatic logic [1:0] ref_len(input logic [7:0] op);
    if (op == 8'h4C) return 2'd3;
    foreach (two_byte_ops[i]) if (two_byte_ops[i] == op) return 2'd2;
    return 2'd1;
  endfunction

  logic [41:0] exp_q[$];
  logic [15:0] model_pc;
  int n_vec = 0;
  int n_err = 0;

  task automatic model_push();
    logic [7:0]  op, o1, o2;
    logic [1:0]  sz;
    logic [15:0] a1, a2;
    a1 = model_pc + 16'd1;
    a2 = model_pc + 16'd2;
    op = mem[model_pc];
    sz = ref_len(op);
    o1 = (sz >= 2'd2) ? mem[a1] : 8'h00;
    o2 = (sz == 2'd3) ? mem[a2] : 8'h00;
    exp_q.push_back({model_pc, op, o1, o2, sz});
    model_pc = model_pc + {14'd0, sz};
  endtask

  // ---------------- drivers ----------------
  task automatic hold_reset();
    rst_n = 1'b0;
    instr_ready = 1'b0;
    instr_ready_w = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset(input logic rd, input logic [15:0] rpc);
    rst_n = 1'b1;
    redirect = rd;
    redirect_pc = rpc;
  endtask

  // Inputs change on the falling edge; outputs are looked at 1 time unit later.
  task automatic cyc(input logic rdy, input logic rd, input logic [15:0] rpc);
    @(negedge clk);
    instr_ready = rdy;
    redirect = rd;
    redirect_pc = rpc;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    mem[16'h0200] = 8'hE8;
    hold_reset();
    #1;
    n_vec++;
    if ({instr_valid, mem_rd, mem_addr} !== 18'd0)
      begin n_err++; $display("FAIL reset_ctrl: got %h want %h", {instr_valid, mem_rd, mem_addr}, 18'd0); end
    n_vec++;
    if ({dut_instr, pc_next} !== {16'h0200, 8'h00, 8'h00, 8'h00, 2'd1, 16'h0201})
      begin n_err++; $display("FAIL reset_fields: got %h want %h", {dut_instr, pc_next}, {16'h0200, 24'h0, 2'd1, 16'h0201}); end
    n_vec++;
    if ({instr_valid_w, dut_instr_w, pc_next_w} !== {1'b0, 16'hFFFE, 24'h0, 2'd1, 16'hFFFF})
      begin n_err++; $display("FAIL reset_fields_w: got %h want %h", {instr_valid_w, dut_instr_w, pc_next_w}, {1'b0, 16'hFFFE, 24'h0, 2'd1, 16'hFFFF}); end
    release_reset(1'b0, 16'h0);
    repeat (3) cyc(1'b0, 1'b0, 16'h0);
    n_vec++;
    if ({instr_valid, dut_instr} !== {1'b1, 16'h0200, 8'hE8, 16'h0, 2'd1})
      begin n_err++; $display("FAIL pre_abort: got %h want %h", {instr_valid, dut_instr}, {1'b1, 16'h0200, 8'hE8, 16'h0, 2'd1}); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({instr_valid, mem_rd, dut_instr} !== {2'b00, 16'h0200, 24'h0, 2'd1})
      begin n_err++; $display("FAIL async_abort: got %h want %h", {instr_valid, mem_rd, dut_instr}, {2'b00, 16'h0200, 24'h0, 2'd1}); end
  endtask

  task automatic test_two_byte();
    logic [16:0] exp_rd [3] = '{{1'b1, 16'h0200}, {1'b1, 16'h0201}, {1'b0, 16'h0000}};
    mem[16'h0200] = 8'hA9;
    mem[16'h0201] = 8'h05;
    hold_reset();
    release_reset(1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      n_vec++;
      if ({instr_valid, mem_rd, mem_addr} !== {1'b0, exp_rd[i]})
        begin n_err++; $display("FAIL two_byte_read%0d: got %h want %h", i, {instr_valid, mem_rd, mem_addr}, {1'b0, exp_rd[i]}); end
    end
    cyc(1'b0, 1'b0, 16'h0);
    n_vec++;
    if ({instr_valid, dut_instr, pc_next} !== {1'b1, 16'h0200, 8'hA9, 8'h05, 8'h00, 2'd2, 16'h0202})
      begin n_err++; $display("FAIL two_byte_instr: got %h want %h", {instr_valid, dut_instr, pc_next}, {1'b1, 16'h0200, 8'hA9, 8'h05, 8'h00, 2'd2, 16'h0202}); end
  endtask

  task automatic test_three_byte();
    logic [16:0] exp_rd [4] = '{{1'b1, 16'h0200}, {1'b1, 16'h0201}, {1'b1, 16'h0202}, {1'b0, 16'h0000}};
    mem[16'h0200] = 8'h4C;
    mem[16'h0201] = 8'h34;
    mem[16'h0202] = 8'h12;
    hold_reset();
    release_reset(1'b0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'h0);
      n_vec++;
      if ({instr_valid, mem_rd, mem_addr} !== {1'b0, exp_rd[i]})
        begin n_err++; $display("FAIL three_byte_read%0d: got %h want %h", i, {instr_valid, mem_rd, mem_addr}, {1'b0, exp_rd[i]}); end
    end
    cyc(1'b1, 1'b0, 16'h0);
    n_vec++;
    if ({instr_valid, dut_instr, pc_next} !== {1'b1, 16'h0200, 8'h4C, 8'h34, 8'h12, 2'd3, 16'h0203})
      begin n_err++; $display("FAIL three_byte_instr: got %h want %h", {instr_valid, dut_instr, pc_next}, {1'b1, 16'h0200, 8'h4C, 8'h34, 8'h12, 2'd3, 16'h0203}); end
    n_vec++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0203})
      begin n_err++; $display("FAIL three_byte_next_read: got %h want %h", {mem_rd, mem_addr}, {1'b1, 16'h0203}); end
  endtask

  task automatic test_stall();
    mem[16'h0200] = 8'hE8;
    hold_reset();
    release_reset(1'b0, 16'h0);
    repeat (2) cyc(1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      n_vec++;
      if ({instr_valid, mem_rd, dut_instr, pc_next} !== {2'b10, 16'h0200, 8'hE8, 16'h0, 2'd1, 16'h0201})
        begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, {instr_valid, mem_rd, dut_instr, pc_next}, {2'b10, 16'h0200, 8'hE8, 16'h0, 2'd1, 16'h0201}); end
    end
    cyc(1'b1, 1'b0, 16'h0);
    n_vec++;
    if ({instr_valid, mem_rd, mem_addr} !== {2'b11, 16'h0201})
      begin n_err++; $display("FAIL stall_accept_read: got %h want %h", {instr_valid, mem_rd, mem_addr}, {2'b11, 16'h0201}); end
    cyc(1'b0, 1'b0, 16'h0);
    n_vec++;
    if (instr_valid !== 1'b0)
      begin n_err++; $display("FAIL stall_drop_valid: got %b want 0", instr_valid); end
  endtask

  task automatic test_redirect();
    int waited;
    mem[16'h0200] = 8'hA9;
    mem[16'h0201] = 8'h05;
    mem[16'h0300] = 8'hE8;
    mem[16'h0400] = 8'hA2;
    mem[16'h0401] = 8'h77;
    // Redirect during the post-reset cycle is ignored.
    hold_reset();
    release_reset(1'b1, 16'h0300);
    cyc(1'b1, 1'b0, 16'h0);
    n_vec++;
    if ({mem_rd, mem_addr} !== {1'b1, 16'h0200})
      begin n_err++; $display("FAIL redirect_in_rst: got %h want %h", {mem_rd, mem_addr}, {1'b1, 16'h0200}); end
    cyc(1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b1, 16'h0300);
    n_vec++;
    if (mem_rd !== 1'b0)
      begin n_err++; $display("FAIL redirect_byte1_rd: got %b want 0", mem_rd); end
    waited = 0;
    do begin cyc(1'b0, 1'b0, 16'h0); waited++; end while (instr_valid !== 1'b1 && waited < 10);
    n_vec++;
    if ({waited[3:0], dut_instr} !== {4'd3, 16'h0300, 8'hE8, 16'h0, 2'd1})
      begin n_err++; $display("FAIL redirect_byte1_target: got %h want %h", {waited[3:0], dut_instr}, {4'd3, 16'h0300, 8'hE8, 16'h0, 2'd1}); end
    // Redirect together with an accept in HOLD.
    cyc(1'b1, 1'b1, 16'h0400);
    n_vec++;
    if (mem_rd !== 1'b0)
      begin n_err++; $display("FAIL redirect_hold_rd: got %b want 0", mem_rd); end
    waited = 0;
    do begin cyc(1'b0, 1'b0, 16'h0); waited++; end while (instr_valid !== 1'b1 && waited < 10);
    n_vec++;
    if ({waited[3:0], dut_instr} !== {4'd4, 16'h0400, 8'hA2, 8'h77, 8'h00, 2'd2})
      begin n_err++; $display("FAIL redirect_hold_target: got %h want %h", {waited[3:0], dut_instr}, {4'd4, 16'h0400, 8'hA2, 8'h77, 8'h00, 2'd2}); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
    hold_reset();
    release_reset(1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 16'h0);
      n_vec++;
      if ({mem_rd_w, mem_addr_w} !== {1'b1, exp_a[i]})
        begin n_err++; $display("FAIL wrap_read%0d: got %h want %h", i, {mem_rd_w, mem_addr_w}, {1'b1, exp_a[i]}); end
    end
    repeat (2) cyc(1'b0, 1'b0, 16'h0);
    n_vec++;
    if ({instr_valid_w, dut_instr_w, pc_next_w} !== {1'b1, 16'hFFFE, 8'h4C, 8'hAA, 8'hBB, 2'd3, 16'h0001})
      begin n_err++; $display("FAIL wrap_instr: got %h want %h", {instr_valid_w, dut_instr_w, pc_next_w}, {1'b1, 16'hFFFE, 8'h4C, 8'hAA, 8'hBB, 2'd3, 16'h0001}); end
    @(negedge clk);
    instr_ready_w = 1'b1;
    #1;
    n_vec++;
    if ({mem_rd_w, mem_addr_w} !== {1'b1, 16'h0001})
      begin n_err++; $display("FAIL wrap_next_read: got %h want %h", {mem_rd_w, mem_addr_w}, {1'b1, 16'h0001}); end
    @(negedge clk);
    instr_ready_w = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] valid_seen;
    mem[16'h0200] = 8'hE8;
    mem[16'h0201] = 8'hE8;
    mem[16'h0202] = 8'hFF;
    exp_q.delete();
    model_pc = 16'h0200;
    repeat (3) model_push();
    hold_reset();
    release_reset(1'b0, 16'h0);
    valid_seen = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 16'h0);
      valid_seen[i] = instr_valid;
      if (instr_valid === 1'b1 && exp_q.size() != 0) begin
        n_vec++;
        if (dut_instr !== exp_q[0])
          begin n_err++; $display("FAIL stream_instr: got %h want %h", dut_instr, exp_q[0]); end
        void'(exp_q.pop_front());
      end
    end
    // Valid on cycles 3, 5 and 7 after reset release.
    n_vec++;
    if (valid_seen !== 8'b0101_0100)
      begin n_err++; $display("FAIL stream_rate: got %b want %b", valid_seen, 8'b0101_0100); end
    n_vec++;
    if (exp_q.size() != 0)
      begin n_err++; $display("FAIL stream_count: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_random();
    logic        rdy, rd, expect_idle;
    logic [15:0] tgt, e_pc, e_next;
    logic [41:0] e;
    int          idle;
    for (int a = 16'h1000; a < 16'h1800; a++) begin
      case ($urandom_range(0, 3))
        0: mem[a] = 8'h4C;
        1: mem[a] = two_byte_ops[$urandom_range(0, 25)];
        default: mem[a] = 8'($urandom);
      endcase
    end
    hold_reset();
    release_reset(1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h1000);
    n_vec++;
    if (mem_rd !== 1'b0)
      begin n_err++; $display("FAIL rand_first_redirect_rd: got %b want 0", mem_rd); end
    exp_q.delete();
    model_pc = 16'h1000;
    expect_idle = 1'b1;
    idle = 0;
    for (int c = 0; c < 600; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      rd  = ($urandom_range(0, 24) == 0);
      tgt = 16'h1000 + 16'($urandom_range(0, 1023));
      cyc(rdy, rd, tgt);
      if (expect_idle) begin
        n_vec++;
        if (instr_valid !== 1'b0)
          begin n_err++; $display("FAIL rand_valid_after_redirect: got %b want 0 at cycle %0d", instr_valid, c); end
      end
      expect_idle = 1'b0;
      if (instr_valid === 1'b1) begin
        if (exp_q.size() == 0) model_push();
        e      = exp_q[0];
        e_pc   = e[41:26];
        e_next = e_pc + {14'd0, e[1:0]};
        n_vec++;
        if ({dut_instr, pc_next} !== {e, e_next})
          begin n_err++; $display("FAIL rand_instr: got %h want %h at cycle %0d", {dut_instr, pc_next}, {e, e_next}, c); end
        if (rdy) begin
          void'(exp_q.pop_front());
          if (!rd) begin
            n_vec++;
            if ({mem_rd, mem_addr} !== {1'b1, e_next})
              begin n_err++; $display("FAIL rand_accept_read: got %h want %h at cycle %0d", {mem_rd, mem_addr}, {1'b1, e_next}, c); end
          end
        end else if (!rd) begin
          n_vec++;
          if (mem_rd !== 1'b0)
            begin n_err++; $display("FAIL rand_stall_rd: got %b want 0 at cycle %0d", mem_rd, c); end
        end
        idle = 0;
      end else begin
        idle++;
        n_vec++;
        if (idle > 4)
          begin n_err++; $display("FAIL rand_latency: got %0d idle cycles want at most 4 at cycle %0d", idle, c); end
      end
      if (rd) begin
        n_vec++;
        if (mem_rd !== 1'b0)
          begin n_err++; $display("FAIL rand_redirect_rd: got %b want 0 at cycle %0d", mem_rd, c); end
        exp_q.delete();
        model_pc = tgt;
        expect_idle = 1'b1;
        idle = 0;
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'hE8;
    mem[16'hFFFE] = 8'h4C;
    mem[16'hFFFF] = 8'hAA;
    mem[16'h0000] = 8'hBB;
    test_reset();
    test_two_byte();
    test_three_byte();
    test_stall();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
